branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
- Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters.
- Replaces the fixed "predict not-taken, flush on taken" policy of the 5-stage pipeline.
- The IF stage looks up the fetch PC and receives a predicted next PC in the same cycle.
- The resolve stage (EX/MEM boundary) writes back the outcome. The block raises redirect with the corrected PC on a mispredict and keeps saturating performance counters.

Parameters:
- ADDR_W, 32, PC and target width.
- INDEX_W, 4, log2 of entry count (16 entries). Legal range 1..10.
- CNT_W, 2, direction counter width. Predict taken when counter MSB = 1.
- STAT_W, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- lookup_en  in  1  IF-stage lookup strobe (used for statistics only)
- lookup_pc  in  ADDR_W  fetch PC
- pred_taken  out  1  prediction for lookup_pc
- pred_next_pc  out  ADDR_W  predicted next fetch PC
- upd_valid  in  1  resolved branch/jump present this cycle
- upd_pc  in  ADDR_W  PC of resolved instruction
- upd_is_jump  in  1  unconditional jump
- upd_taken  in  1  actual direction
- upd_target  in  ADDR_W  actual target
- upd_pred_taken  in  1  prediction carried down the pipe for this instruction
- upd_pred_target  in  ADDR_W  predicted next PC carried down the pipe
- redirect  out  1  mispredict: flush younger stages
- redirect_pc  out  ADDR_W  corrected fetch PC
- stat_clr  in  1  synchronous clear of the statistics counters
- stat_lookups  out  STAT_W  count of lookup_en cycles
- stat_updates  out  STAT_W  count of upd_valid cycles
- stat_mispredicts  out  STAT_W  count of redirect cycles

Behaviour:
- Addressing:
  - index = pc[INDEX_W+1:2].
  - tag = pc[ADDR_W-1:INDEX_W+2].
  - pc[1:0] is ignored.
- Entry state: valid (1b), tag, target (ADDR_W), counter (CNT_W).
- Reset (async, rst=1):
  - All valid bits clear, all counters = 2^(CNT_W-1)-1 (weakly not-taken), targets and tags = 0.
  - Statistics counters = 0.
  - While in reset: pred_taken = 0, pred_next_pc = lookup_pc+4, and redirect = 0 regardless of inputs.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx] == lookup tag).
  - pred_taken = hit & counter[idx][MSB].
  - pred_next_pc = pred_taken ? target[idx] : lookup_pc+4.
  - lookup_pc+4 wraps modulo 2^ADDR_W.
- Mispredict (combinational from upd_* inputs):
  - redirect = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & (upd_target != upd_pred_target))).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - redirect is 0 when upd_valid = 0.
- Update (on the clk edge when upd_valid = 1):
  - Tag hit at upd index:
    - upd_is_jump sets the counter to all-ones.
    - Otherwise the counter increments if taken, decrements if not taken, saturating at all-ones and 0.
    - If taken, target is written with upd_target.
  - Tag miss and upd_taken = 1: allocate by overwriting the entry. Set valid = 1, tag, target = upd_target, counter = 2^(CNT_W-1) (weakly taken), or all-ones if upd_is_jump.
  - Tag miss and upd_taken = 0: no state change.
- Simultaneous lookup and update to the same index in one cycle: the lookup returns pre-update contents (no bypass). The new state is visible from the next cycle.
- Statistics:
  - Each counter increments by 1 per qualifying cycle and saturates at 2^STAT_W-1 (no wrap).
  - stat_clr has priority over increment in the same cycle.
- Reset mid-operation: every pending update is discarded and no partial entry write occurs.

Test Plan:
- Reset, then lookup_pc=0x00400010 -> pred_taken=0, pred_next_pc=0x00400014. Update with upd_taken=0 while rst=1 -> redirect=0.
- Update pc=0x00400010, taken, target=0x00400040, pred_taken=0 -> redirect=1, redirect_pc=0x00400040. Next cycle, lookup 0x00400010 -> pred_taken=1, pred_next_pc=0x00400040.
- Train the same branch: two not-taken updates (counter 10→01→00) -> lookup pred_taken=0, pred_next_pc=0x00400014. Two taken updates (00→01→10) -> pred_taken=1.
- Aliasing with INDEX_W=4: 0x00400010 allocated, then taken update at 0x00400050 (same index, different tag) -> lookup 0x00400010 misses (pc+4), lookup 0x00400050 hits.
- Same-cycle lookup and allocate at index 4 -> that cycle pred_taken=0; following cycle pred_taken=1. Jump update gives counter=11, needing two not-taken updates to flip.
- STAT_W=3: 9 lookup_en cycles -> stat_lookups=7. Assert stat_clr together with lookup_en -> 0 next cycle. Correct prediction -> stat_mispredicts unchanged, stat_updates+1.

Source files
------------

// File: rtl/branch_predictor_btb_if.sv
// Lookup, update and statistics signals of the branch target buffer.
// master = pipeline side (drives lookups and resolved outcomes),
// slave  = predictor side.
interface branch_predictor_btb_if #(
    parameter int ADDR_W = 32,
    parameter int STAT_W = 16
);
    logic              lookup_en;
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_next_pc;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_is_jump;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_target;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              stat_clr;
    logic [STAT_W-1:0] stat_lookups;
    logic [STAT_W-1:0] stat_updates;
    logic [STAT_W-1:0] stat_mispredicts;

    modport master (
        output lookup_en, lookup_pc, upd_valid, upd_pc, upd_is_jump, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target, stat_clr,
        input  pred_taken, pred_next_pc, redirect, redirect_pc,
               stat_lookups, stat_updates, stat_mispredicts
    );

    modport slave (
        input  lookup_en, lookup_pc, upd_valid, upd_pc, upd_is_jump, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target, stat_clr,
        output pred_taken, pred_next_pc, redirect, redirect_pc,
               stat_lookups, stat_updates, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational (same-cycle prediction for the IF stage); the
// resolve stage writes outcomes back and gets an immediate redirect on a
// mispredict. Lookups see pre-update table contents (no write bypass).
module branch_predictor_btb #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 4,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predictor_btb_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_WNT   = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]  CNT_WT    = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0] PC_STEP   = {{(ADDR_W-3){1'b0}}, 3'b100};
    localparam logic [STAT_W-1:0] STAT_ZERO = {STAT_W{1'b0}};
    localparam logic [STAT_W-1:0] STAT_ONE  = {{(STAT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};

    // Saturating +1 used by every statistics counter.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? STAT_MAX : (v + STAT_ONE);
    endfunction

    // Table storage
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];

    logic [STAT_W-1:0]  lookups_q, updates_q, mispredicts_q;

    // Lookup path
    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic               lk_taken;
    logic [ADDR_W-1:0]  lk_seq_pc;

    assign lk_idx    = bus.lookup_pc[INDEX_W+1:2];
    assign lk_tag    = bus.lookup_pc[ADDR_W-1:INDEX_W+2];
    assign lk_seq_pc = bus.lookup_pc + PC_STEP;
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1] && !rst;

    assign bus.pred_taken   = lk_taken;
    assign bus.pred_next_pc = lk_taken ? target_q[lk_idx] : lk_seq_pc;

    // Resolve path
    logic [INDEX_W-1:0] upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic               upd_mis;
    logic               redirect_s;

    assign upd_idx    = bus.upd_pc[INDEX_W+1:2];
    assign upd_tag    = bus.upd_pc[ADDR_W-1:INDEX_W+2];
    assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_mis    = (bus.upd_taken != bus.upd_pred_taken) ||
                        (bus.upd_taken && (bus.upd_target != bus.upd_pred_target));
    assign redirect_s = bus.upd_valid && upd_mis && !rst;

    assign bus.redirect    = redirect_s;
    assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : (bus.upd_pc + PC_STEP);

    // Next contents of the entry addressed by the resolved instruction
    logic              upd_we;
    logic [ADDR_W-1:0] target_d;
    logic [CNT_W-1:0]  cnt_d;

    // Decide whether and how the resolved branch trains/allocates its entry.
    always_comb begin
        upd_we   = 1'b0;
        target_d = target_q[upd_idx];
        cnt_d    = cnt_q[upd_idx];
        if (bus.upd_valid) begin
            if (upd_hit) begin
                upd_we = 1'b1;
                if (bus.upd_is_jump) begin
                    cnt_d = CNT_MAX;
                end else if (bus.upd_taken) begin
                    cnt_d = (cnt_q[upd_idx] == CNT_MAX) ? CNT_MAX : (cnt_q[upd_idx] + CNT_ONE);
                end else begin
                    cnt_d = (cnt_q[upd_idx] == CNT_ZERO) ? CNT_ZERO : (cnt_q[upd_idx] - CNT_ONE);
                end
                if (bus.upd_taken) begin
                    target_d = bus.upd_target;
                end else begin
                    target_d = target_q[upd_idx];
                end
            end else if (bus.upd_taken) begin
                upd_we   = 1'b1;
                target_d = bus.upd_target;
                cnt_d    = bus.upd_is_jump ? CNT_MAX : CNT_WT;
            end else begin
                upd_we = 1'b0;
            end
        end else begin
            upd_we = 1'b0;
        end
    end

    // Table write; reset wipes every entry so no partial write survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= {TAG_W{1'b0}};
                target_q[i] <= {ADDR_W{1'b0}};
                cnt_q[i]    <= CNT_WNT;
            end
        end else if (upd_we) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= target_d;
            cnt_q[upd_idx]    <= cnt_d;
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookups_q     <= STAT_ZERO;
            updates_q     <= STAT_ZERO;
            mispredicts_q <= STAT_ZERO;
        end else if (bus.stat_clr) begin
            lookups_q     <= STAT_ZERO;
            updates_q     <= STAT_ZERO;
            mispredicts_q <= STAT_ZERO;
        end else begin
            lookups_q     <= bus.lookup_en ? sat_inc(lookups_q)     : lookups_q;
            updates_q     <= bus.upd_valid ? sat_inc(updates_q)     : updates_q;
            mispredicts_q <= redirect_s    ? sat_inc(mispredicts_q) : mispredicts_q;
        end
    end

    assign bus.stat_lookups     = lookups_q;
    assign bus.stat_updates     = updates_q;
    assign bus.stat_mispredicts = mispredicts_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed scenarios plus
// randomized traffic against a table-level reference model.
module tb_branch_predictor_btb;
    localparam int ADDR_W  = 32;
    localparam int INDEX_W = 4;
    localparam int CNT_W   = 2;
    localparam int STAT_W  = 3;
    localparam int N       = 16;
    localparam int SMAX    = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    branch_predictor_btb_if #(.ADDR_W(ADDR_W), .STAT_W(STAT_W)) bus();

    branch_predictor_btb #(
        .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W), .STAT_W(STAT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_valid  [N];
    logic [31:0] m_tag    [N];
    logic [31:0] m_target [N];
    int          m_cnt    [N];
    int          m_lk, m_up, m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (INDEX_W + 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_target[i] = 32'd0; m_cnt[i] = 1;
        end
        m_lk = 0; m_up = 0; m_mis = 0;
    endtask

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_next(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_redirect();
        if (rst) return 1'b0;
        return bus.upd_valid && ((bus.upd_taken != bus.upd_pred_taken) ||
               (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
    endfunction

    function automatic logic [31:0] m_redirect_pc();
        return bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;
    endfunction

    function automatic int sat(input int v);
        return (v >= SMAX) ? SMAX : v + 1;
    endfunction

    // Apply what the clock edge does to the model, then move to next negedge.
    task automatic next_cycle();
        bit mis;
        int i;
        mis = m_redirect();
        if (rst) begin
            model_reset();
        end else begin
            if (bus.upd_valid) begin
                i = idx_of(bus.upd_pc);
                if (m_hit(bus.upd_pc)) begin
                    if (bus.upd_is_jump) m_cnt[i] = 3;
                    else if (bus.upd_taken) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                    else m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                    if (bus.upd_taken) m_target[i] = bus.upd_target;
                end else if (bus.upd_taken) begin
                    m_valid[i] = 1'b1; m_tag[i] = tag_of(bus.upd_pc);
                    m_target[i] = bus.upd_target; m_cnt[i] = bus.upd_is_jump ? 3 : 2;
                end
            end
            if (bus.stat_clr) begin
                m_lk = 0; m_up = 0; m_mis = 0;
            end else begin
                if (bus.lookup_en) m_lk = sat(m_lk);
                if (bus.upd_valid) m_up = sat(m_up);
                if (mis)           m_mis = sat(m_mis);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.lookup_en = 1'b0; bus.lookup_pc = 32'd0; bus.upd_valid = 1'b0;
        bus.upd_pc = 32'd0; bus.upd_is_jump = 1'b0; bus.upd_taken = 1'b0;
        bus.upd_target = 32'd0; bus.upd_pred_taken = 1'b0;
        bus.upd_pred_target = 32'd0; bus.stat_clr = 1'b0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input bit tk, input bit jmp,
                           input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_taken = tk; bus.upd_is_jump = jmp;
        bus.upd_target = tgt; bus.upd_pred_taken = ptk; bus.upd_pred_target = ptgt;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bus.lookup_en = 1'b1; bus.lookup_pc = pc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle(); lookup(32'h00400010);
        set_upd(32'h00400010, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00400040);
        #1;
        if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%0b exp=0", bus.pred_taken); end
        checks++;
        if (bus.pred_next_pc !== 32'h00400014) begin failures++; $display("FAIL reset_next_pc got=%h exp=00400014", bus.pred_next_pc); end
        checks++;
        if (bus.redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%0b exp=0", bus.redirect); end
        checks++;
        if (bus.stat_lookups !== 3'd0 || bus.stat_updates !== 3'd0 || bus.stat_mispredicts !== 3'd0) begin
            failures++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", bus.stat_lookups, bus.stat_updates, bus.stat_mispredicts);
        end
        checks++;
        next_cycle();
        set_upd(32'h00400010, 1'b1, 1'b0, 32'h00400040, 1'b0, 32'h00400014);
        #1;
        if (bus.redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect_taken got=%0b exp=0", bus.redirect); end
        checks++;
        next_cycle();
        rst = 1'b0;
        idle(); lookup(32'h00400010);
        #1;
        if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL reset_no_alloc got=%0b exp=0", bus.pred_taken); end
        checks++;
        next_cycle();
    endtask

    task automatic test_allocate();
        idle(); set_upd(32'h00400010, 1'b1, 1'b0, 32'h00400040, 1'b0, 32'h00400014);
        #1;
        if (bus.redirect !== 1'b1) begin failures++; $display("FAIL alloc_redirect got=%0b exp=1", bus.redirect); end
        checks++;
        if (bus.redirect_pc !== 32'h00400040) begin failures++; $display("FAIL alloc_redirect_pc got=%h exp=00400040", bus.redirect_pc); end
        checks++;
        next_cycle();
        idle(); lookup(32'h00400010);
        #1;
        if (bus.pred_taken !== 1'b1 || bus.pred_next_pc !== 32'h00400040) begin
            failures++; $display("FAIL alloc_lookup got=%0b/%h exp=1/00400040", bus.pred_taken, bus.pred_next_pc);
        end
        checks++;
        next_cycle();
    endtask

    task automatic test_training();
        for (int k = 0; k < 2; k++) begin
            idle(); set_upd(32'h00400010, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00400040);
            #1;
            if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h00400014) begin
                failures++; $display("FAIL train_nt_redirect got=%0b/%h exp=1/00400014", bus.redirect, bus.redirect_pc);
            end
            checks++;
            next_cycle();
        end
        idle(); lookup(32'h00400010);
        #1;
        if (bus.pred_taken !== 1'b0 || bus.pred_next_pc !== 32'h00400014) begin
            failures++; $display("FAIL train_nt_lookup got=%0b/%h exp=0/00400014", bus.pred_taken, bus.pred_next_pc);
        end
        checks++;
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            idle(); set_upd(32'h00400010, 1'b1, 1'b0, 32'h00400040, 1'b0, 32'h00400014);
            next_cycle();
            idle(); lookup(32'h00400010);
            #1;
            if (bus.pred_taken !== (k == 1)) begin
                failures++; $display("FAIL train_t_lookup step=%0d got=%0b exp=%0b", k, bus.pred_taken, (k == 1));
            end
            checks++;
            next_cycle();
        end
    endtask

    task automatic test_aliasing();
        idle(); set_upd(32'h00400050, 1'b1, 1'b0, 32'h00400090, 1'b0, 32'h00400054);
        next_cycle();
        idle(); lookup(32'h00400010);
        #1;
        if (bus.pred_taken !== 1'b0 || bus.pred_next_pc !== 32'h00400014) begin
            failures++; $display("FAIL alias_old got=%0b/%h exp=0/00400014", bus.pred_taken, bus.pred_next_pc);
        end
        checks++;
        next_cycle();
        idle(); lookup(32'h00400050);
        #1;
        if (bus.pred_taken !== 1'b1 || bus.pred_next_pc !== 32'h00400090) begin
            failures++; $display("FAIL alias_new got=%0b/%h exp=1/00400090", bus.pred_taken, bus.pred_next_pc);
        end
        checks++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        idle(); lookup(32'h00800010);
        set_upd(32'h00800010, 1'b1, 1'b0, 32'h00800100, 1'b0, 32'h00800014);
        #1;
        if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL b2b_same_cycle got=%0b exp=0", bus.pred_taken); end
        checks++;
        next_cycle();
        idle(); lookup(32'h00800010);
        #1;
        if (bus.pred_taken !== 1'b1 || bus.pred_next_pc !== 32'h00800100) begin
            failures++; $display("FAIL b2b_next_cycle got=%0b/%h exp=1/00800100", bus.pred_taken, bus.pred_next_pc);
        end
        checks++;
        next_cycle();
        idle(); set_upd(32'h00C00014, 1'b1, 1'b1, 32'h00C00100, 1'b0, 32'h00C00018);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            idle(); set_upd(32'h00C00014, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00C00100);
            next_cycle();
            idle(); lookup(32'h00C00014);
            #1;
            if (bus.pred_taken !== (k == 0)) begin
                failures++; $display("FAIL jump_hyst step=%0d got=%0b exp=%0b", k, bus.pred_taken, (k == 0));
            end
            checks++;
            next_cycle();
        end
    endtask

    task automatic test_stats();
        idle(); lookup(32'h0); bus.stat_clr = 1'b1;
        next_cycle();
        for (int k = 0; k < 9; k++) begin
            idle(); lookup(32'h00001000 + 32'(k * 4));
            next_cycle();
        end
        idle(); lookup(32'h0); bus.stat_clr = 1'b1;
        #1;
        if (bus.stat_lookups !== 3'd7) begin failures++; $display("FAIL stat_sat got=%0d exp=7", bus.stat_lookups); end
        checks++;
        next_cycle();
        idle(); set_upd(32'h00400050, 1'b1, 1'b0, 32'h00400090, 1'b1, 32'h00400090);
        #1;
        if (bus.stat_lookups !== 3'd0) begin failures++; $display("FAIL stat_clr got=%0d exp=0", bus.stat_lookups); end
        checks++;
        if (bus.redirect !== 1'b0) begin failures++; $display("FAIL stat_correct_redirect got=%0b exp=0", bus.redirect); end
        checks++;
        next_cycle();
        idle();
        #1;
        if (bus.stat_updates !== 3'd1 || bus.stat_mispredicts !== 3'd0) begin
            failures++; $display("FAIL stat_correct got=%0d/%0d exp=1/0", bus.stat_updates, bus.stat_mispredicts);
        end
        checks++;
        next_cycle();
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h00400000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
    endfunction

    task automatic test_random();
        logic [31:0] upc, lpc, tgt;
        bit          tk;
        for (int c = 0; c < 300; c++) begin
            idle();
            lpc = rand_pc(); upc = rand_pc();
            tgt = {$urandom_range(0, 255), 2'b00} + 32'h00500000;
            tk  = $urandom_range(0, 1);
            bus.lookup_en = $urandom_range(0, 3) != 0; bus.lookup_pc = lpc;
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 2) != 0)
                    set_upd(upc, tk, $urandom_range(0, 7) == 0, tgt, m_pred_taken(upc), m_pred_next(upc));
                else
                    set_upd(upc, tk, 1'b0, tgt, $urandom_range(0, 1), {$urandom_range(0, 255), 2'b00} + 32'h00500000);
            end
            bus.stat_clr = $urandom_range(0, 15) == 0;
            #1;
            if (bus.pred_taken !== m_pred_taken(lpc) || bus.pred_next_pc !== m_pred_next(lpc)) begin
                failures++; $display("FAIL rnd_lookup cyc=%0d pc=%h got=%0b/%h exp=%0b/%h", c, lpc,
                    bus.pred_taken, bus.pred_next_pc, m_pred_taken(lpc), m_pred_next(lpc));
            end
            checks++;
            if (bus.redirect !== m_redirect() || (m_redirect() && bus.redirect_pc !== m_redirect_pc())) begin
                failures++; $display("FAIL rnd_redirect cyc=%0d got=%0b/%h exp=%0b/%h", c,
                    bus.redirect, bus.redirect_pc, m_redirect(), m_redirect_pc());
            end
            checks++;
            if (int'(bus.stat_lookups) != m_lk || int'(bus.stat_updates) != m_up || int'(bus.stat_mispredicts) != m_mis) begin
                failures++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c,
                    bus.stat_lookups, bus.stat_updates, bus.stat_mispredicts, m_lk, m_up, m_mis);
            end
            checks++;
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        idle(); lookup(32'h00400050);
        set_upd(32'h01000020, 1'b1, 1'b0, 32'h01000100, 1'b0, 32'h01000024);
        #1;
        rst = 1'b1;
        #1;
        if (bus.redirect !== 1'b0 || bus.pred_taken !== 1'b0) begin
            failures++; $display("FAIL mid_reset_outputs got=%0b/%0b exp=0/0", bus.redirect, bus.pred_taken);
        end
        checks++;
        if (bus.stat_updates !== 3'd0) begin failures++; $display("FAIL mid_reset_stats got=%0d exp=0", bus.stat_updates); end
        checks++;
        next_cycle();
        rst = 1'b0;
        idle(); lookup(32'h01000020);
        #1;
        if (bus.pred_taken !== 1'b0 || bus.pred_next_pc !== 32'h01000024) begin
            failures++; $display("FAIL mid_reset_discard got=%0b/%h exp=0/01000024", bus.pred_taken, bus.pred_next_pc);
        end
        checks++;
        next_cycle();
    endtask

    initial begin
        model_reset();
        idle();
        @(negedge clk);
        test_reset();
        test_allocate();
        test_training();
        test_aliasing();
        test_back_to_back();
        test_stats();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
